mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port between two cache refill requesters.
// One transaction in flight; a response timeout aborts a transaction if the memory never answers.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid1,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Counter value seen on the last BUSY cycle before the abort fires.
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e                  state_q;
  logic                    owner_q;       // port holding the current transaction
  logic                    last_grant_q;  // port that most recently finished
  logic [TO_W-1:0]         cnt_q;
  logic                    mem_req_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    gnt0_q;
  logic                    gnt1_q;
  logic [DATA_WIDTH-1:0]   rdata0_q;
  logic [DATA_WIDTH-1:0]   rdata1_q;
  logic                    rvalid0_q;
  logic                    rvalid1_q;
  logic                    timeout_err_q;

  logic grant_any;
  logic grant_sel;
  logic timeout_hit;
  logic owner_req;

  // NOTE: every signal written here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    grant_any   = req0 | req1;
    // Port 1 wins when it is alone, or when both ask and port 0 went last.
    grant_sel   = req1 & (~req0 | ~last_grant_q);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    owner_req   = owner_q ? req1 : req0;
  end

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  // NOTE: the data registers are reset too, because they drive outputs that must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            owner_q    <= grant_sel;
            mem_addr_q <= grant_sel ? addr1 : addr0;
            gnt0_q     <= ~grant_sel;
            gnt1_q     <= grant_sel;
            mem_req_q  <= 1'b1;
            cnt_q      <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + TO_W'(1);
          // A response arriving on the timeout cycle still counts as success.
          if (mem_rvalid) begin
            mem_req_q    <= 1'b0;
            last_grant_q <= owner_q;
            state_q      <= RESP;
            if (owner_q) begin
              rdata1_q  <= mem_rdata;
              rvalid1_q <= owner_req;
            end else begin
              rdata0_q  <= mem_rdata;
              rvalid0_q <= owner_req;
            end
          end else if (timeout_hit) begin
            mem_req_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            last_grant_q  <= owner_q;
            state_q       <= RESP;
          end
        end
        RESP: begin
          rvalid0_q     <= 1'b0;
          rvalid1_q     <= 1'b0;
          timeout_err_q <= 1'b0;
          gnt0_q        <= 1'b0;
          gnt1_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all outputs
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0  = 1'b0;
  logic          req1  = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] mem_rdata  = '0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1, mem_req, gnt0, gnt1, timeout_err;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .gnt0(gnt0), .gnt1(gnt1), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  bit            rand_mode   = 1'b0;
  bit            mem_silent  = 1'b0;
  int            mem_lat     = 3;
  logic [DW-1:0] mem_data    = '0;
  bit            spur_pending = 1'b0;
  logic [DW-1:0] spur_data   = '0;
  int            mcnt        = 0;
  int            cur_lat     = 0;

  initial forever begin
    @(negedge clk);
    if (spur_pending) begin
      mem_rvalid   = 1'b1;
      mem_rdata    = spur_data;
      spur_pending = 1'b0;
    end else if (mem_req && rst_n) begin
      if (mcnt == 0) cur_lat = rand_mode ? int'($urandom_range(1, 10)) : mem_lat;
      mcnt++;
      if (!mem_silent && mcnt == cur_lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rand_mode ? DW'($urandom()) : mem_data;
      end else begin
        mem_rvalid = 1'b0;
      end
    end else begin
      mcnt       = 0;
      mem_rvalid = 1'b0;
      if (rand_mode && rst_n && $urandom_range(0, 9) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = DW'($urandom());
      end
    end
  end

  // ---------------- inputs as seen by each rising edge ----------------
  bit            s_rst = 1'b1;
  bit            s_req [2];
  logic [AW-1:0] s_addr[2];
  bit            s_mrv;
  logic [DW-1:0] s_mrd;

  always @(posedge clk) begin
    s_rst     <= !rst_n;
    s_req[0]  <= req0;
    s_req[1]  <= req1;
    s_addr[0] <= addr0;
    s_addr[1] <= addr1;
    s_mrv     <= mem_rvalid;
    s_mrd     <= mem_rdata;
  end

  // ---------------- transaction-level reference model ----------------
  int            m_owner  = -1;  // port with a transaction in flight, -1 when none
  int            m_age    = 0;   // rising edges spent waiting on memory
  int            m_last   = 1;   // port whose transaction finished most recently
  bit            m_window = 1'b0; // the single result cycle after a finish
  bit            e_mem_req;
  logic [AW-1:0] e_mem_addr;
  bit            e_gnt[2];
  bit            e_rv [2];
  bit            e_to;
  logic [DW-1:0] e_rd [2];

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_last = 1; m_window = 1'b0;
    e_mem_req = 1'b0; e_mem_addr = '0; e_to = 1'b0;
    for (int p = 0; p < 2; p++) begin
      e_gnt[p] = 1'b0; e_rv[p] = 1'b0; e_rd[p] = '0;
    end
  endtask

  task automatic model_step();
    int w;
    if (m_window) begin
      e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_to = 1'b0;
      e_gnt[0] = 1'b0; e_gnt[1] = 1'b0;
      m_window = 1'b0;
      m_owner  = -1;
    end else if (m_owner < 0) begin
      w = -1;
      if (s_req[0] && s_req[1]) w = 1 - m_last;
      else if (s_req[0])        w = 0;
      else if (s_req[1])        w = 1;
      if (w >= 0) begin
        m_owner    = w;
        m_age      = 0;
        e_mem_req  = 1'b1;
        e_mem_addr = s_addr[w];
        e_gnt[w]   = 1'b1;
      end
    end else begin
      m_age++;
      if (s_mrv) begin
        e_mem_req     = 1'b0;
        e_rd[m_owner] = s_mrd;
        e_rv[m_owner] = s_req[m_owner];
        m_last        = m_owner;
        m_window      = 1'b1;
      end else if (TO != 0 && m_age == TO) begin
        e_mem_req = 1'b0;
        e_to      = 1'b1;
        m_last    = m_owner;
        m_window  = 1'b1;
      end
    end
  endtask

  // ---------------- monitor + per-cycle compare ----------------
  int            g_port[$];
  logic [AW-1:0] g_addr[$];
  int            cnt_rv0 = 0, cnt_rv1 = 0, cnt_to = 0;
  int            rise_cyc = 0, to_cyc = 0;
  bit            prev_mreq = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n || s_rst) model_reset();
    else model_step();
    if (!rst_n) begin
      prev_mreq = 1'b0;
    end else begin
      if (mem_req && !prev_mreq) begin
        g_port.push_back(gnt0 ? 0 : (gnt1 ? 1 : -1));
        g_addr.push_back(mem_addr);
        rise_cyc = cyc;
      end
      prev_mreq = mem_req;
      if (rvalid0) cnt_rv0++;
      if (rvalid1) cnt_rv1++;
      if (timeout_err) begin
        cnt_to++;
        to_cyc = cyc;
      end
    end
    check("mem_req", 64'(mem_req), 64'(e_mem_req));
    if (e_mem_req) check("mem_addr", 64'(mem_addr), 64'(e_mem_addr));
    check("gnt0", 64'(gnt0), 64'(e_gnt[0]));
    check("gnt1", 64'(gnt1), 64'(e_gnt[1]));
    check("rvalid0", 64'(rvalid0), 64'(e_rv[0]));
    check("rvalid1", 64'(rvalid1), 64'(e_rv[1]));
    check("timeout_err", 64'(timeout_err), 64'(e_to));
    check("rdata0", 64'(rdata0), 64'(e_rd[0]));
    check("rdata1", 64'(rdata1), 64'(e_rd[1]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int count_of(input int kind);
    case (kind)
      0:       return cnt_rv0;
      1:       return cnt_rv1;
      2:       return cnt_to;
      3:       return g_port.size();
      default: return cnt_rv0 + cnt_rv1;
    endcase
  endfunction

  // kind: 0 rvalid0, 1 rvalid1, 2 timeouts, 3 grants, 4 rvalid0+rvalid1
  task automatic wait_count(input int kind, input int target, input string name);
    int i = 0;
    while (count_of(kind) < target && i < 60) begin
      tick();
      i++;
    end
    check(name, 64'(count_of(kind) >= target), 64'd1);
  endtask

  task automatic clear_logs();
    g_port.delete();
    g_addr.delete();
    cnt_rv0 = 0; cnt_rv1 = 0; cnt_to = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_miss=%0d", n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_gnt", 64'({gnt0, gnt1}), 64'd0);
    check("reset_rvalid_to", 64'({rvalid0, rvalid1, timeout_err}), 64'd0);
    check("reset_rdata", 64'({rdata0, rdata1}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single port 0 transaction, requester drops req right after rvalid0.
    clear_logs();
    mem_lat = 3; mem_data = 32'hDEAD_BEEF;
    addr0 = 32'h0000_1040; req0 = 1'b1;
    wait_count(0, 1, "t1_rvalid0_seen");
    check("t1_rdata0", 64'(rdata0), 64'h0000_0000_DEAD_BEEF);
    req0 = 1'b0;
    repeat (6) tick();
    check("t1_one_grant", 64'(g_port.size()), 64'd1);
    if (g_port.size() >= 1) begin
      check("t1_port", 64'(g_port[0]), 64'd0);
      check("t1_addr", 64'(g_addr[0]), 64'h1040);
    end
    check("t1_rv0_count", 64'(cnt_rv0), 64'd1);
    check("t1_rv1_count", 64'(cnt_rv1), 64'd0);

    // Both ports hold requests from reset: alternate 0,1,0,1.
    do_reset();
    clear_logs();
    mem_lat = 2; mem_data = 32'h5555_AAAA;
    addr0 = 32'h100; addr1 = 32'h200;
    req0 = 1'b1; req1 = 1'b1;
    wait_count(4, 4, "t2_four_done");
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();
    check("t2_grants", 64'(g_port.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < g_port.size()) begin
        check("t2_port", 64'(g_port[k]), 64'(k % 2));
        check("t2_addr", 64'(g_addr[k]), (k % 2 == 0) ? 64'h100 : 64'h200);
      end
    end

    // Silent memory on port 1: timeout 8 cycles after mem_req, then implicit retry.
    clear_logs();
    mem_silent = 1'b1;
    addr1 = 32'h300; req1 = 1'b1;
    wait_count(2, 1, "t3_timeout_seen");
    check("t3_to_distance", 64'(to_cyc - rise_cyc), 64'd8);
    check("t3_mem_req_low", 64'(mem_req), 64'd0);
    check("t3_rvalid1_low", 64'(rvalid1), 64'd0);
    mem_silent = 1'b0; mem_lat = 4; mem_data = 32'h1234_5678;
    wait_count(1, 1, "t3_retry_done");
    check("t3_rdata1", 64'(rdata1), 64'h1234_5678);
    req1 = 1'b0;
    repeat (3) tick();
    check("t3_grants", 64'(g_port.size()), 64'd2);

    // Requester abandons its request mid-transaction; then a spurious valid in IDLE.
    clear_logs();
    mem_lat = 5; mem_data = 32'h0BAD_0BAD;
    addr0 = 32'h400; req0 = 1'b1;
    wait_count(3, 1, "t4_granted");
    req0 = 1'b0;
    addr0 = 32'hFFFF_FFC0;
    repeat (12) tick();
    check("t4_no_rvalid0", 64'(cnt_rv0), 64'd0);
    check("t4_no_timeout", 64'(cnt_to), 64'd0);
    check("t4_idle_mem_req", 64'(mem_req), 64'd0);
    check("t4_rdata0", 64'(rdata0), 64'h0BAD_0BAD);
    spur_data = 32'hCAFE_F00D; spur_pending = 1'b1;
    repeat (4) tick();
    check("t4_spur_rdata0", 64'(rdata0), 64'h0BAD_0BAD);
    check("t4_spur_rdata1", 64'(rdata1), 64'h1234_5678);
    check("t4_spur_rvalids", 64'(cnt_rv0 + cnt_rv1), 64'd0);
    check("t4_spur_grants", 64'(g_port.size()), 64'd1);

    // Asynchronous reset while BUSY, then both request: port 0 must win.
    clear_logs();
    mem_silent = 1'b1;
    addr0 = 32'h500; req0 = 1'b1;
    wait_count(3, 1, "t5_granted");
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_mem_req", 64'(mem_req), 64'd0);
    check("t5_async_gnt", 64'({gnt0, gnt1}), 64'd0);
    check("t5_async_out", 64'({rvalid0, rvalid1, timeout_err}), 64'd0);
    mem_silent = 1'b0; mem_lat = 2; mem_data = 32'h7777_0001;
    addr1 = 32'h600; req1 = 1'b1;
    clear_logs();
    tick();
    rst_n = 1'b1;
    wait_count(0, 1, "t5_port0_done");
    req0 = 1'b0;
    wait_count(1, 1, "t5_port1_done");
    req1 = 1'b0;
    repeat (3) tick();
    if (g_port.size() >= 2) begin
      check("t5_first_port", 64'(g_port[0]), 64'd0);
      check("t5_first_addr", 64'(g_addr[0]), 64'h500);
      check("t5_second_port", 64'(g_port[1]), 64'd1);
    end else begin
      check("t5_grants", 64'(g_port.size()), 64'd2);
    end

    // Randomized traffic: latencies straddle the timeout, spurious valids, drops, addr churn.
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (req0) begin
        if ((rvalid0 && $urandom_range(0, 3) != 0) || $urandom_range(0, 63) == 0) req0 = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req0 = 1'b1;
      end
      if (req1) begin
        if ((rvalid1 && $urandom_range(0, 3) != 0) || $urandom_range(0, 63) == 0) req1 = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req1 = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) addr0 = $urandom() & 32'hFFFF_FFC0;
      if ($urandom_range(0, 7) == 0) addr1 = $urandom() & 32'hFFFF_FFC0;
    end
    req0 = 1'b0; req1 = 1'b0;
    rand_mode = 1'b0;
    repeat (30) tick();
    check("end_idle", 64'({mem_req, gnt0, gnt1}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
